// File: rtl/wb_reg_checker.sv
// wb_reg_checker: watches the register-file writeback port, keeps a shadow
// copy of the architectural registers and runs an ordered table of register
// checks (WAIT = wait until equal, CHECK = must equal now), reporting
// pass / fail / timeout with diagnostics.
module wb_reg_checker #(
  parameter int NUM_CHECKS = 8,
  parameter int XLEN       = 32,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_en,
  input  logic [4:0]                    wb_addr,
  input  logic [XLEN-1:0]               wb_data,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_CHECKS)-1:0] cfg_idx,
  input  logic [4:0]                    cfg_reg,
  input  logic [XLEN-1:0]               cfg_value,
  input  logic                          cfg_mode,
  input  logic [$clog2(NUM_CHECKS):0]   num_active,
  input  logic [TIMEOUT_W-1:0]          timeout_limit,
  input  logic                          start,
  output logic                          busy,
  output logic                          pass,
  output logic                          fail,
  output logic                          timeout,
  output logic [$clog2(NUM_CHECKS):0]   check_ptr,
  output logic [XLEN-1:0]               fail_data,
  output logic [TIMEOUT_W-1:0]          cycle_count
);

  localparam int IDXW = $clog2(NUM_CHECKS);
  localparam int PW   = IDXW + 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_PASS    = 3'd2;
  localparam logic [2:0] ST_FAIL    = 3'd3;
  localparam logic [2:0] ST_TIMEOUT = 3'd4;

  localparam logic MODE_CHECK = 1'b1;

  // Shadow register file; x0 is not stored and always reads as zero.
  logic [XLEN-1:0] shadow_q [1:31];

  // Check table.
  logic [4:0]      tbl_reg_q  [NUM_CHECKS];
  logic [XLEN-1:0] tbl_val_q  [NUM_CHECKS];
  logic            tbl_mode_q [NUM_CHECKS];

  // Run control and status.
  logic [2:0]           state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        num_q, num_d;
  logic [TIMEOUT_W-1:0] limit_q, limit_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]      fdata_q, fdata_d;
  logic                 pass_q, pass_d;
  logic                 fail_q, fail_d;
  logic                 tmo_q, tmo_d;

  // Current-entry view.
  logic [IDXW-1:0]      cur_idx;
  logic [4:0]           cur_reg;
  logic [XLEN-1:0]      cur_val;
  logic                 cur_mode;
  logic [XLEN-1:0]      shadow_rd;
  logic [XLEN-1:0]      eff_val;
  logic                 match;
  logic [PW-1:0]        ptr_inc;
  logic                 last_entry;
  logic [TIMEOUT_W-1:0] cnt_inc;
  logic                 timeout_hit;
  logic [PW-1:0]        num_clamped;
  logic                 cfg_allowed;

  // Shadow register writes happen in every state, independent of the run.
  for (genvar gi = 1; gi < 32; gi++) begin : g_shadow
    always_ff @(posedge clk) begin
      if (!rst) begin
        shadow_q[gi] <= '0;
      end else if (wb_en && (wb_addr == 5'(gi))) begin
        shadow_q[gi] <= wb_data;
      end
    end
  end

  assign cfg_allowed = (state_q != ST_RUN);

  // Check-table entries are only reprogrammable while no run is in progress.
  for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_table
    always_ff @(posedge clk) begin
      if (!rst) begin
        tbl_reg_q[gi]  <= '0;
        tbl_val_q[gi]  <= '0;
        tbl_mode_q[gi] <= 1'b0;
      end else if (cfg_we && cfg_allowed && (cfg_idx == IDXW'(gi))) begin
        tbl_reg_q[gi]  <= cfg_reg;
        tbl_val_q[gi]  <= cfg_value;
        tbl_mode_q[gi] <= cfg_mode;
      end
    end
  end

  assign cur_idx  = ptr_q[IDXW-1:0];
  assign cur_reg  = tbl_reg_q[cur_idx];
  assign cur_val  = tbl_val_q[cur_idx];
  assign cur_mode = tbl_mode_q[cur_idx];

  // Effective value of the checked register, bypassing a same-cycle write so
  // a value produced this cycle can satisfy the check immediately.
  always_comb begin
    shadow_rd = '0;
    if (cur_reg != 5'd0) begin
      shadow_rd = shadow_q[cur_reg];
    end
    eff_val = shadow_rd;
    if (wb_en && (wb_addr == cur_reg) && (cur_reg != 5'd0)) begin
      eff_val = wb_data;
    end
  end

  assign match       = (eff_val == cur_val);
  assign ptr_inc     = ptr_q + 1'b1;
  assign last_entry  = (ptr_inc == num_q);
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign timeout_hit = (limit_q != '0) && (cnt_inc == limit_q);
  assign num_clamped = (num_active > PW'(NUM_CHECKS)) ? PW'(NUM_CHECKS) : num_active;

  // Next-state logic for the run sequencer; priority inside RUN is
  // final match, then CHECK mismatch, then timeout.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    num_d   = num_q;
    limit_d = limit_q;
    cnt_d   = cnt_q;
    fdata_d = fdata_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (match) begin
          ptr_d = ptr_inc;
          if (last_entry) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end else if (timeout_hit) begin
            state_d = ST_TIMEOUT;
            tmo_d   = 1'b1;
            fdata_d = eff_val;
          end
        end else if (cur_mode == MODE_CHECK) begin
          state_d = ST_FAIL;
          fail_d  = 1'b1;
          fdata_d = eff_val;
        end else if (timeout_hit) begin
          state_d = ST_TIMEOUT;
          tmo_d   = 1'b1;
          fdata_d = eff_val;
        end
      end
      default: begin
        if (start) begin
          ptr_d   = '0;
          cnt_d   = '0;
          fdata_d = '0;
          fail_d  = 1'b0;
          tmo_d   = 1'b0;
          num_d   = num_clamped;
          limit_d = timeout_limit;
          if (num_clamped == '0) begin
            state_d = ST_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            pass_d  = 1'b0;
          end
        end
      end
    endcase
  end

  // Sequencer state and sticky status registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      num_q   <= '0;
      limit_q <= '0;
      cnt_q   <= '0;
      fdata_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      num_q   <= num_d;
      limit_q <= limit_d;
      cnt_q   <= cnt_d;
      fdata_q <= fdata_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy        = (state_q == ST_RUN);
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign timeout     = tmo_q;
  assign check_ptr   = ptr_q;
  assign fail_data   = fdata_q;
  assign cycle_count = cnt_q;

endmodule

// File: tb/tb_wb_reg_checker.sv
// Directed bench for wb_reg_checker: each run pushes its expected outcome to a
// scoreboard queue, and the entry is popped and compared when the run ends.
module tb_wb_reg_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic [4:0]  cfg_reg;
  logic [31:0] cfg_value;
  logic        cfg_mode;
  logic [3:0]  num_active;
  logic [15:0] timeout_limit;
  logic        start;
  logic        busy, pass, fail, timeout;
  logic [3:0]  check_ptr;
  logic [31:0] fail_data;
  logic [15:0] cycle_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        pass;
    logic        fail;
    logic        tmo;
    logic [3:0]  ptr;
    logic [31:0] fdata;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  wb_reg_checker #(.NUM_CHECKS(8), .XLEN(32), .TIMEOUT_W(16)) dut (
    .clk(clk), .rst(rst),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_reg(cfg_reg),
    .cfg_value(cfg_value), .cfg_mode(cfg_mode),
    .num_active(num_active), .timeout_limit(timeout_limit), .start(start),
    .busy(busy), .pass(pass), .fail(fail), .timeout(timeout),
    .check_ptr(check_ptr), .fail_data(fail_data), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic cfg(input logic [2:0] idx, input logic [4:0] r, input logic [31:0] v, input logic m);
    cfg_we = 1'b1; cfg_idx = idx; cfg_reg = r; cfg_value = v; cfg_mode = m;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_run(input string name, input logic [3:0] n, input logic [15:0] lim,
                           input logic ep, input logic ef, input logic et,
                           input logic [3:0] eptr, input logic [31:0] efd, input logic [15:0] ecnt);
    exp_t e;
    e.name = name; e.pass = ep; e.fail = ef; e.tmo = et;
    e.ptr = eptr; e.fdata = efd; e.cnt = ecnt;
    sb.push_back(e);
    num_active = n; timeout_limit = lim; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done();
    exp_t e;
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!busy && (pass || fail || timeout)) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    e = sb.pop_front();
    chk({e.name, "_done"}, 64'(done), 64'd1);
    chk({e.name, "_busy"}, 64'(busy), 64'd0);
    chk({e.name, "_pass"}, 64'(pass), 64'(e.pass));
    chk({e.name, "_fail"}, 64'(fail), 64'(e.fail));
    chk({e.name, "_timeout"}, 64'(timeout), 64'(e.tmo));
    chk({e.name, "_ptr"}, 64'(check_ptr), 64'(e.ptr));
    chk({e.name, "_fail_data"}, 64'(fail_data), 64'(e.fdata));
    chk({e.name, "_cycle_count"}, 64'(cycle_count), 64'(e.cnt));
    $display("run %s: pass=%0d fail=%0d timeout=%0d ptr=%0d fail_data=%0d cycles=%0d",
             e.name, pass, fail, timeout, check_ptr, fail_data, cycle_count);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_pass"}, 64'(pass), 64'd0);
    chk({tag, "_fail"}, 64'(fail), 64'd0);
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    chk({tag, "_ptr"}, 64'(check_ptr), 64'd0);
    chk({tag, "_fail_data"}, 64'(fail_data), 64'd0);
    chk({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
  endtask

  initial begin
    rst = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_reg = '0; cfg_value = '0; cfg_mode = 1'b0;
    num_active = '0; timeout_limit = '0; start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // Reset state.
    check_idle("reset");

    // Cleared table entry 0 is {x0, 0, WAIT}: satisfied at once.
    start_run("default_entry", 4'd1, 16'd0, 1'b1, 1'b0, 1'b0, 4'd1, 32'd0, 16'd1);
    wait_done();

    // WAIT satisfied by a write on RUN cycle 10.
    cfg(3'd0, 5'd14, 32'd14, 1'b0);
    start_run("wait_x14", 4'd1, 16'd100, 1'b1, 1'b0, 1'b0, 4'd1, 32'd0, 16'd10);
    chk("wait_x14_busy_early", 64'(busy), 64'd1);
    repeat (9) tick();
    chk("wait_x14_busy_c10", 64'(busy), 64'd1);
    chk("wait_x14_nopass_c10", 64'(pass), 64'd0);
    wb(5'd14, 32'd14);
    wait_done();

    // CHECK mismatch fails right after the first evaluation.
    wb(5'd1, 32'd499);
    cfg(3'd0, 5'd1, 32'd500, 1'b1);
    start_run("check_x1", 4'd1, 16'd100, 1'b0, 1'b1, 1'b0, 4'd0, 32'd499, 16'd1);
    tick();
    chk("check_x1_fail_next", 64'(fail), 64'd1);
    wait_done();

    // WAIT never satisfied: timeout after 20 RUN cycles.
    wb(5'd2, 32'd77);
    cfg(3'd0, 5'd2, 32'd100, 1'b0);
    start_run("timeout_x2", 4'd1, 16'd20, 1'b0, 1'b0, 1'b1, 4'd0, 32'd77, 16'd20);
    wait_done();

    // Writes to x0 are discarded.
    wb(5'd0, 32'd7);
    cfg(3'd0, 5'd0, 32'd0, 1'b1);
    start_run("x0_check", 4'd1, 16'd100, 1'b1, 1'b0, 1'b0, 4'd1, 32'd0, 16'd1);
    wait_done();

    // Final match via bypass on the same cycle the limit is reached.
    cfg(3'd0, 5'd1, 32'd5, 1'b0);
    cfg(3'd1, 5'd2, 32'd6, 1'b0);
    start_run("bypass_limit", 4'd2, 16'd3, 1'b1, 1'b0, 1'b0, 4'd2, 32'd0, 16'd3);
    wb(5'd1, 32'd5);
    tick();
    wb(5'd2, 32'd6);
    wait_done();

    // num_active == 0 passes immediately.
    start_run("zero_active", 4'd0, 16'd10, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 16'd0);
    wait_done();

    // Config writes during RUN are ignored.
    cfg(3'd0, 5'd5, 32'd1, 1'b0);
    start_run("cfg_locked", 4'd1, 16'd5, 1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 16'd5);
    cfg(3'd0, 5'd5, 32'd0, 1'b0);
    wait_done();

    // Reset in the middle of a WAIT run.
    wb(5'd3, 32'd9);
    cfg(3'd0, 5'd3, 32'd1, 1'b0);
    num_active = 4'd1; timeout_limit = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("midrun_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_idle("midrun_reset");
    cfg(3'd0, 5'd3, 32'd0, 1'b1);
    start_run("after_reset", 4'd1, 16'd0, 1'b1, 1'b0, 1'b0, 4'd1, 32'd0, 16'd1);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_reg_checker.md
Name: wb_reg_checker

Overview:
- Synthesizable, parametrised self-check block that watches the CPU register-file writeback port and runs an ordered list of register checks.
- Each check is either a wait-until-equal or an immediate check-equal.
- Raises pass, fail or timeout status with diagnostics.
- Sits beside the cpu in FPGA top or bench, so the same checks run on hardware and in simulation.

Parameters:
- NUM_CHECKS, 8, number of check-table entries (power of two, >= 2).
- XLEN, 32, register data width.
- TIMEOUT_W, 16, width of the timeout limit and cycle counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-low (0 = reset).
- wb_en  input  1  register-file write enable from writeback stage.
- wb_addr  input  5  writeback destination register.
- wb_data  input  XLEN  writeback data.
- cfg_we  input  1  check-table write strobe.
- cfg_idx  input  $clog2(NUM_CHECKS)  table entry written.
- cfg_reg  input  5  register number for the entry.
- cfg_value  input  XLEN  expected value.
- cfg_mode  input  1  0 = WAIT (wait until equal), 1 = CHECK (must equal now).
- num_active  input  $clog2(NUM_CHECKS)+1  checks to run, 0..NUM_CHECKS.
- timeout_limit  input  TIMEOUT_W  cycle budget for the whole run.
- start  input  1  begin a run (single-cycle pulse).
- busy  output  1  run in progress.
- pass  output  1  all checks satisfied (sticky until start or reset).
- fail  output  1  a CHECK entry mismatched (sticky).
- timeout  output  1  budget exhausted (sticky).
- check_ptr  output  $clog2(NUM_CHECKS)+1  index of current or last evaluated check.
- fail_data  output  XLEN  shadow value seen at failure or timeout.
- cycle_count  output  TIMEOUT_W  cycles elapsed in current or last run.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0.
  - Shadow register file (32 x XLEN) clears to 0.
  - Check table clears to reg 0, value 0, mode WAIT.
- Shadow RF:
  - On each cycle with wb_en and wb_addr != 0, shadow[wb_addr] <= wb_data, in every state.
  - Writes to x0 are ignored; x0 always reads 0.
- Effective value: the shadow read of the current check's register bypasses the same-cycle write. If wb_en, wb_addr == reg and reg != 0, use wb_data.
- Config:
  - cfg_we writes the entry at cfg_idx only in IDLE, PASS, FAIL or TIMEOUT.
  - cfg_we is ignored while busy.
  - num_active and timeout_limit are sampled on start.
- States: IDLE, RUN, PASS, FAIL, TIMEOUT.
- Start:
  - start in any non-RUN state enters RUN next cycle.
  - Clears pass, fail, timeout, check_ptr, cycle_count and fail_data. The shadow RF is not cleared.
  - start during RUN is ignored.
- Start with num_active == 0: go directly to PASS next cycle.
- RUN, each cycle:
  - cycle_count increments.
  - At most one check (entry check_ptr) is evaluated.
  - Match: effective value == expected. Then check_ptr increments. If it was the last active entry, next state is PASS.
  - Mismatch in CHECK mode: next state is FAIL, and fail_data latches the effective value.
  - Mismatch in WAIT mode: stay on the entry.
  - Timeout: cycle_count reaching timeout_limit with the run incomplete gives TIMEOUT next cycle, with fail_data set to the effective value of the current entry.
- Priority in one cycle: final-check match > CHECK mismatch > timeout.
- timeout_limit == 0 disables the timeout.
- busy == 1 exactly in RUN.
- Status outputs assert the cycle after the deciding evaluation and hold until start or reset.
- Latency: a WAIT check already satisfied on entry completes in 1 cycle, so N satisfied checks take N cycles to PASS.
- Reset mid-run aborts immediately to IDLE with all state cleared; no status is reported.
- cycle_count saturates at all-ones.

Test Plan:
- Program entry0 = {x14, 14, WAIT}, num_active = 1, limit = 100; start. Write x14 = 14 on cycle 10. Required: pass asserted on cycle 11 of RUN, busy deasserts, check_ptr = 1.
- Program entry0 = {x1, 500, CHECK} with x1 previously written 499; start. Required: fail the cycle after start, check_ptr = 0, fail_data = 499.
- Program entry0 = {x2, 100, WAIT}, limit = 20, no write to x2. Required: timeout after 20 RUN cycles, cycle_count = 20, pass = 0.
- Write x0 = 7 via writeback, then run entry {x0, 0, CHECK}. Required: pass; x0 is not written.
- Program entries {x1, 5, WAIT}, {x2, 6, WAIT}, limit = 3. Write x1 = 5 on cycle 1, x2 = 6 on cycle 3 (same cycle the limit is reached). Required: pass, not timeout; the bypass is used.
- Start a run, assert rst low mid-wait for 1 cycle. Required: all outputs 0 and state IDLE. A following cfg_we is accepted, and a re-run with shadow cleared matches {x3, 0, CHECK}.
